// File: rtl/nco_enable_bank.sv
// Multi-channel phase-accumulator NCO that emits single-cycle clock-enable strobes.
// Each channel supports continuous or counted-burst operation with live increment retuning.
module nco_enable_bank #(
  parameter int                   ACC_WIDTH   = 20,
  parameter int                   CHANNELS    = 4,
  parameter int                   COUNT_WIDTH = 16,
  parameter logic [ACC_WIDTH-1:0] INIT_INC    = {ACC_WIDTH{1'b0}},
  localparam int                  CH_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [CH_BITS-1:0]            cfg_ch,
  input  logic [ACC_WIDTH-1:0]          cfg_inc,
  input  logic [COUNT_WIDTH-1:0]        cfg_len,
  input  logic [CHANNELS-1:0]           start,
  input  logic [CHANNELS-1:0]           stop,
  output logic [CHANNELS-1:0]           enable,
  output logic [CHANNELS-1:0]           done,
  output logic [CHANNELS*ACC_WIDTH-1:0] phase
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [ACC_WIDTH-1:0]   inc_r   [CHANNELS];
  logic [COUNT_WIDTH-1:0] len_r   [CHANNELS];
  logic [ACC_WIDTH-1:0]   acc_r   [CHANNELS];
  logic [COUNT_WIDTH-1:0] rem_r   [CHANNELS];
  state_t                 state_r [CHANNELS];
  logic [CHANNELS-1:0]    enable_r;
  logic [CHANNELS-1:0]    done_r;

  logic [ACC_WIDTH:0]     sum_s   [CHANNELS];
  logic [CHANNELS-1:0]    sel_s;

  // Per-channel accumulator sum with carry, and config-write channel decode.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_s[c] = {1'b0, acc_r[c]} + {1'b0, inc_r[c]};
      sel_s[c] = cfg_we && (cfg_ch == CH_BITS'(c));
    end
  end

  // Channel state machines: config registers, accumulators, burst counters and strobes.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset) begin
        inc_r[c]    <= INIT_INC;
        len_r[c]    <= {COUNT_WIDTH{1'b0}};
        acc_r[c]    <= {ACC_WIDTH{1'b0}};
        rem_r[c]    <= {COUNT_WIDTH{1'b0}};
        state_r[c]  <= ST_IDLE;
        enable_r[c] <= 1'b0;
        done_r[c]   <= 1'b0;
      end else begin
        if (sel_s[c]) begin
          inc_r[c] <= cfg_inc;
          len_r[c] <= cfg_len;
        end
        if (stop[c]) begin
          state_r[c]  <= ST_IDLE;
          acc_r[c]    <= {ACC_WIDTH{1'b0}};
          enable_r[c] <= 1'b0;
          done_r[c]   <= 1'b0;
        end else if (start[c]) begin
          // len_r is read before any same-cycle write lands, so a restart keeps the old length.
          state_r[c]  <= ST_RUN;
          acc_r[c]    <= {ACC_WIDTH{1'b0}};
          rem_r[c]    <= len_r[c];
          enable_r[c] <= 1'b0;
          done_r[c]   <= 1'b0;
        end else begin
          case (state_r[c])
            ST_RUN: begin
              acc_r[c]    <= sum_s[c][ACC_WIDTH-1:0];
              enable_r[c] <= sum_s[c][ACC_WIDTH];
              // A latched remaining of zero means continuous mode.
              if (sum_s[c][ACC_WIDTH] && (rem_r[c] != {COUNT_WIDTH{1'b0}})) begin
                rem_r[c] <= rem_r[c] - COUNT_WIDTH'(1'b1);
                if (rem_r[c] == COUNT_WIDTH'(1'b1)) begin
                  state_r[c] <= ST_DONE;
                  done_r[c]  <= 1'b1;
                end
              end
            end
            ST_DONE: begin
              enable_r[c] <= 1'b0;
              done_r[c]   <= 1'b1;
            end
            ST_IDLE: begin
              acc_r[c]    <= {ACC_WIDTH{1'b0}};
              enable_r[c] <= 1'b0;
              done_r[c]   <= 1'b0;
            end
            default: begin
              state_r[c]  <= ST_IDLE;
              acc_r[c]    <= {ACC_WIDTH{1'b0}};
              enable_r[c] <= 1'b0;
              done_r[c]   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign enable = enable_r;
  assign done   = done_r;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_phase
    assign phase[g*ACC_WIDTH +: ACC_WIDTH] = acc_r[g];
  end

endmodule

// File: tb/tb_nco_enable_bank.sv
// Directed self-checking bench for nco_enable_bank; a second 3-channel instance
// covers out-of-range config writes and a non-zero reset increment.
module tb_nco_enable_bank;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [19:0] cfg_inc;
  logic [15:0] cfg_len;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [3:0]  enable;
  logic [3:0]  done;
  logic [79:0] phase;

  logic        b_cfg_we;
  logic [1:0]  b_cfg_ch;
  logic [19:0] b_cfg_inc;
  logic [15:0] b_cfg_len;
  logic [2:0]  b_start;
  logic [2:0]  b_stop;
  logic [2:0]  b_enable;
  logic [2:0]  b_done;
  logic [59:0] b_phase;

  int checks = 0;
  int errors = 0;
  longint n1 = 0;

  nco_enable_bank dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
    .cfg_len(cfg_len), .start(start), .stop(stop), .enable(enable), .done(done), .phase(phase)
  );

  nco_enable_bank #(.CHANNELS(3), .INIT_INC(20'h08000)) dut_b (
    .clk(clk), .reset(reset), .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch), .cfg_inc(b_cfg_inc),
    .cfg_len(b_cfg_len), .start(b_start), .stop(b_stop), .enable(b_enable), .done(b_done),
    .phase(b_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n1++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    int last;
    int bad;
    int first;
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_inc = 20'h0; cfg_len = 16'h0;
    start = 4'h0; stop = 4'h0;
    b_cfg_we = 1'b0; b_cfg_ch = 2'd0; b_cfg_inc = 20'h0; b_cfg_len = 16'h0;
    b_start = 3'b000; b_stop = 3'b000;
    tick(); tick();
    check("rst_enable", enable, 4'h0);
    check("rst_done", done, 4'h0);
    check("rst_phase", phase, 80'h0);
    reset = 1'b0;

    // Out-of-range write on the 3-channel instance; all channels keep INIT_INC.
    b_cfg_we = 1'b1; b_cfg_ch = 2'd3; b_cfg_inc = 20'h70000; tick(); b_cfg_we = 1'b0;
    b_start = 3'b111; tick(); b_start = 3'b000;
    tick(); tick();
    for (int c = 0; c < 3; c++) check("oor_phase", b_phase[c*20 +: 20], 20'h10000);

    // Rate: ch0 at one half.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 20'h80000; cfg_len = 16'h0; tick(); cfg_we = 1'b0;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    check("rate_p0", phase[19:0], 20'h0);
    tick();
    check("rate_e1", enable[0], 1'b0);
    check("rate_p1", phase[19:0], 20'h80000);
    tick();
    check("rate_e2", enable[0], 1'b1);
    for (int n = 3; n < 9; n++) begin
      tick();
      check("rate_en", enable[0], (n % 2) == 0);
    end

    // Fractional: ch1 at ~0.2 for 1000 cycles.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_inc = 20'h33333; tick(); cfg_we = 1'b0;
    start[1] = 1'b1; tick(); start[1] = 1'b0; n1 = 0;
    cnt = 0; last = 0; bad = 0; first = 0;
    for (int n = 1; n <= 1000; n++) begin
      tick();
      if (enable[1]) begin
        cnt++;
        if (first == 0) first = n;
        if (last != 0 && (n - last) != 5 && (n - last) != 6) bad++;
        last = n;
      end
    end
    check("frac_first", first, 6);
    check("frac_count", cnt, (1000 * 64'h33333) >> 20);
    check("frac_bad_intervals", bad, 0);

    // Burst: ch2, len 3, run twice.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_inc = 20'h40000; cfg_len = 16'd3; tick(); cfg_we = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      start[2] = 1'b1; tick(); start[2] = 1'b0;
      check("burst_done_clr", done[2], 1'b0);
      check("burst_p0", phase[59:40], 20'h0);
      for (int n = 1; n <= 16; n++) begin
        tick();
        check("burst_en", enable[2], (n % 4 == 0) && (n <= 12));
        check("burst_done", done[2], n >= 12);
      end
    end

    // Live retune of ch0 while ch1 keeps running.
    for (int i = 0; i < 4 && !enable[0]; i++) tick();
    check("retune_sync", enable[0], 1'b1);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 20'h40000; tick(); cfg_we = 1'b0;
    check("retune_p0", phase[19:0], 20'h80000);
    for (int n = 1; n <= 8; n++) begin
      tick();
      check("retune_en", enable[0], (n % 4) == 2);
      check("retune_phase", phase[19:0], (64'h80000 + n * 64'h40000) & 64'hFFFFF);
      check("retune_ch1", phase[39:20], (n1 * 64'h33333) & 64'hFFFFF);
    end

    // Precedence: start and stop together on running ch3.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_inc = 20'h10000; tick(); cfg_we = 1'b0;
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    check("prec_run", phase[79:60], 20'h50000);
    start[3] = 1'b1; stop[3] = 1'b1; tick(); start[3] = 1'b0; stop[3] = 1'b0;
    check("prec_phase", phase[79:60], 20'h0);
    check("prec_en", enable[3], 1'b0);
    tick(); tick(); tick();
    check("prec_idle", phase[79:60], 20'h0);

    // Stop from DONE.
    check("stop_pre_done", done[2], 1'b1);
    stop[2] = 1'b1; tick(); stop[2] = 1'b0;
    check("stop_done", done[2], 1'b0);

    // Same-cycle write and start: old len 3 loads, new inc drives the next add.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_inc = 20'h80000; cfg_len = 16'd1; start[2] = 1'b1;
    tick(); cfg_we = 1'b0; start[2] = 1'b0;
    tick();
    check("same_p1", phase[59:40], 20'h80000);
    check("same_e1", enable[2], 1'b0);
    tick();
    check("same_e2", enable[2], 1'b1);
    check("same_old_len", done[2], 1'b0);
    tick();
    check("same_e3", enable[2], 1'b0);

    // Reset mid-burst, then confirm increments reverted to INIT_INC.
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_en", enable, 4'h0);
    check("mid_rst_done", done, 4'h0);
    check("mid_rst_phase", phase, 80'h0);
    start = 4'hF; tick(); start = 4'h0;
    tick(); tick(); tick();
    check("init_inc_phase", phase, 80'h0);
    check("init_inc_en", enable, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
